// File: rtl/overlay_pkg.sv
// Shared constants and box classification for the debug overlay compositor.
// Colours are RGB332; player-state codes select which slot is drawn as an attack box.
package overlay_pkg;

    localparam logic [7:0] RED         = 8'hE0;
    localparam logic [7:0] YELLOW      = 8'hFC;
    localparam logic [7:0] TRANSPARENT = 8'hE3;
    localparam logic [7:0] BACKGROUND  = 8'h7B;

    localparam logic [3:0] ST_HIT_ACTIVE  = 4'd4;
    localparam logic [3:0] ST_HIT_PASSIVE = 4'd5;
    localparam logic [3:0] ST_DIR_ACTIVE  = 4'd7;
    localparam logic [3:0] ST_DIR_PASSIVE = 4'd8;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        HURT    = 2'd1,
        PASSIVE = 2'd2,
        ACTIVE  = 2'd3
    } box_class_e;

    // Slot 0 is the hithurt box, slot 1 the directional one, the rest are pure hurt boxes.
    function automatic box_class_e box_class(input int slot, input logic [3:0] st);
        box_class_e c;
        c = NONE;
        if (slot == 0) begin
            if (st == ST_HIT_ACTIVE)       c = ACTIVE;
            else if (st == ST_HIT_PASSIVE) c = PASSIVE;
        end else if (slot == 1) begin
            if (st == ST_DIR_ACTIVE)       c = ACTIVE;
            else if (st == ST_DIR_PASSIVE) c = PASSIVE;
        end else begin
            c = HURT;
        end
        return c;
    endfunction

endpackage

// File: rtl/box_border_detect.sv
// Combinational 1-pixel rectangle border test for one box.
// A box with x1>x2 or y1>y2 is treated as absent and never draws.
module box_border_detect #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] y2,
    output logic               on_border
);

    logic valid_box;
    logic on_vert;
    logic on_horz;

    always_comb begin
        valid_box = (x1 <= x2) && (y1 <= y2);
        on_vert   = ((x == x1) || (x == x2)) && (y >= y1) && (y <= y2);
        on_horz   = ((y == y1) || (y == y2)) && (x >= x1) && (x <= x2);
        on_border = valid_box && (on_vert || on_horz);
    end

endmodule

// File: rtl/box_overlay_pipe.sv
// Debug overlay: draws hit/hurt box borders over sprite pixels with a fixed 2-cycle latency.
// Box geometry and mode bits are shadowed at frame_start so a frame never tears.
module box_overlay_pipe
    import overlay_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int BOXES_PER_PLAYER = 3,
    parameter int COORD_W          = 10,
    parameter int COLOR_W          = 8,
    parameter int BLINK_FRAMES     = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [COORD_W-1:0]                             pixel_x,
    input  logic [COORD_W-1:0]                             pixel_y,
    input  logic                                           pixel_valid,
    input  logic [COLOR_W-1:0]                             pixel_data,
    input  logic                                           frame_start,
    input  logic [NUM_PLAYERS*BOXES_PER_PLAYER*4*COORD_W-1:0] box_coords,
    input  logic [NUM_PLAYERS*4-1:0]                       player_state,
    input  logic                                           debug_en,
    input  logic                                           blink_en,
    output logic [COLOR_W-1:0]                             color_out,
    output logic                                           color_valid
);

    localparam int NB    = NUM_PLAYERS * BOXES_PER_PLAYER;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NB*4*COORD_W-1:0] sh_coords;
    logic [NUM_PLAYERS*4-1:0] sh_state;
    logic                     sh_debug;
    logic                     sh_blink;
    logic [CNT_W-1:0]         blink_cnt;
    logic                     blink_phase;

    logic [NB-1:0] on_border;
    logic          any_active;
    logic          any_passive;
    logic          any_hurt;

    logic               s1_active;
    logic               s1_passive;
    logic               s1_hurt;
    logic [COLOR_W-1:0] s1_data;
    logic               s1_valid;
    logic [COLOR_W-1:0] next_color;

    for (genvar i = 0; i < NB; i++) begin : g_box
        box_border_detect #(.COORD_W(COORD_W)) u_detect (
            .x        (pixel_x),
            .y        (pixel_y),
            .x1       (sh_coords[(i*4+0)*COORD_W +: COORD_W]),
            .x2       (sh_coords[(i*4+1)*COORD_W +: COORD_W]),
            .y1       (sh_coords[(i*4+2)*COORD_W +: COORD_W]),
            .y2       (sh_coords[(i*4+3)*COORD_W +: COORD_W]),
            .on_border(on_border[i])
        );
    end

    // A blinked-off active box disappears entirely rather than falling back to passive.
    always_comb begin
        box_class_e cls;
        any_active  = 1'b0;
        any_passive = 1'b0;
        any_hurt    = 1'b0;
        cls         = NONE;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int b = 0; b < BOXES_PER_PLAYER; b++) begin
                cls = box_class(b, sh_state[p*4 +: 4]);
                if (!sh_debug) cls = NONE;
                else if (cls == ACTIVE && sh_blink && blink_phase) cls = NONE;
                if (on_border[p*BOXES_PER_PLAYER + b]) begin
                    case (cls)
                        ACTIVE:  any_active  = 1'b1;
                        PASSIVE: any_passive = 1'b1;
                        HURT:    any_hurt    = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        if (s1_active)                              next_color = COLOR_W'(RED);
        else if (s1_passive || s1_hurt)             next_color = COLOR_W'(YELLOW);
        else if (s1_data == COLOR_W'(TRANSPARENT))  next_color = COLOR_W'(BACKGROUND);
        else                                        next_color = s1_data;
    end

    // Valid-only stream: pixel_valid travels with its pixel, there is no ready/backpressure,
    // and color_out is forced to 0 whenever color_valid is 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_coords   <= '0;
            sh_state    <= '0;
            sh_debug    <= 1'b0;
            sh_blink    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            s1_active   <= 1'b0;
            s1_passive  <= 1'b0;
            s1_hurt     <= 1'b0;
            s1_data     <= '0;
            s1_valid    <= 1'b0;
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            if (frame_start) begin
                sh_coords <= box_coords;
                sh_state  <= player_state;
                sh_debug  <= debug_en;
                sh_blink  <= blink_en;
                if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
            s1_active   <= any_active;
            s1_passive  <= any_passive;
            s1_hurt     <= any_hurt;
            s1_data     <= pixel_data;
            s1_valid    <= pixel_valid;
            color_valid <= s1_valid;
            color_out   <= s1_valid ? next_color : '0;
        end
    end

endmodule

// File: tb/tb_box_overlay_pipe.sv
// Bench for box_overlay_pipe: table-driven pixel vectors plus hand-written frame,
// blink and reset sequences; expected colours flow through a due-cycle queue.
module tb_box_overlay_pipe;

    localparam int NP   = 2;
    localparam int BPP  = 3;
    localparam int CW   = 10;
    localparam int NB   = NP * BPP;
    localparam int EW   = 32 + 1 + 8;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [7:0]    d;
        logic [7:0]    e;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CW-1:0]     pixel_x;
    logic [CW-1:0]     pixel_y;
    logic              pixel_valid;
    logic [7:0]        pixel_data;
    logic              frame_start;
    logic [NB*4*CW-1:0] box_coords;
    logic [NP*4-1:0]   player_state;
    logic              debug_en;
    logic              blink_en;
    logic [7:0]        color_out;
    logic              color_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] ent;
    vec_t          tab[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    box_overlay_pipe #(
        .NUM_PLAYERS(NP), .BOXES_PER_PLAYER(BPP), .COORD_W(CW), .COLOR_W(8), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data), .frame_start(frame_start),
        .box_coords(box_coords), .player_state(player_state), .debug_en(debug_en),
        .blink_en(blink_en), .color_out(color_out), .color_valid(color_valid)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic v,
                        input logic [7:0] d, input logic fs, input logic [7:0] e, input logic push);
        pixel_x     = x;
        pixel_y     = y;
        pixel_valid = v;
        pixel_data  = d;
        frame_start = fs;
        if (push) exp_q.push_back({32'(cyc + 2), v, (v ? e : 8'h00)});
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        step('0, '0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic set_box(input int p, input int b, input int x1, input int x2,
                           input int y1, input int y2);
        box_coords[((p*BPP+b)*4+0)*CW +: CW] = CW'(x1);
        box_coords[((p*BPP+b)*4+1)*CW +: CW] = CW'(x2);
        box_coords[((p*BPP+b)*4+2)*CW +: CW] = CW'(y1);
        box_coords[((p*BPP+b)*4+3)*CW +: CW] = CW'(y2);
    endtask

    task automatic set_state(input int p, input logic [3:0] s);
        player_state[p*4 +: 4] = s;
    endtask

    task automatic add(input int x, input int y, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.x = CW'(x);
        v.y = CW'(y);
        v.d = d;
        v.e = e;
        tab.push_back(v);
    endtask

    task automatic run_tab();
        for (int i = 0; i < tab.size(); i++)
            step(tab[i].x, tab[i].y, 1'b1, tab[i].d, 1'b0, tab[i].e, 1'b1);
        tab.delete();
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h, want %02h", name, got, want);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ent = exp_q[0];
            if (ent[40:9] == 32'(cyc)) begin
                void'(exp_q.pop_front());
                checks++;
                if (color_valid !== ent[8] || color_out !== ent[7:0]) begin
                    errors++;
                    $display("FAIL pixel@cyc%0d: got valid=%0b color=%02h, want valid=%0b color=%02h",
                             cyc, color_valid, color_out, ent[8], ent[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        pixel_x      = '0;
        pixel_y      = '0;
        pixel_valid  = 1'b0;
        pixel_data   = '0;
        frame_start  = 1'b0;
        box_coords   = '0;
        player_state = '0;
        debug_en     = 1'b1;
        blink_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset color_out", color_out, 8'h00);
        chk("reset color_valid", {7'd0, color_valid}, 8'h00);
        rst_n = 1'b1;

        // 1: single hurt box
        set_box(0, 2, 100, 150, 200, 260);
        pulse_fs();
        add(100, 220, 8'h55, 8'hFC);
        add(101, 220, 8'hE3, 8'h7B);
        add(150, 260, 8'h12, 8'hFC);
        add(125, 200, 8'h12, 8'hFC);
        add(125, 261, 8'h33, 8'h33);
        add( 99, 220, 8'h44, 8'h44);
        add(150, 199, 8'h44, 8'h44);
        run_tab();
        step(100, 220, 1'b0, 8'h55, 1'b0, 8'h00, 1'b1);

        // 2: active over hurt, state change held until frame_start
        set_box(0, 2, 300, 400, 120, 200);
        set_box(1, 0, 300, 340, 100, 140);
        set_state(1, 4'd4);
        pulse_fs();
        add(300, 120, 8'h10, 8'hE0);
        add(320, 100, 8'h10, 8'hE0);
        add(350, 120, 8'h10, 8'hFC);
        add(320, 120, 8'h10, 8'hFC);
        add(340, 140, 8'h10, 8'hE0);
        add(341, 140, 8'h10, 8'h10);
        run_tab();
        set_state(1, 4'd5);
        set_state(0, 4'd7);
        set_box(0, 1, 500, 520, 10, 20);
        add(300, 120, 8'h10, 8'hE0);
        add(510,  10, 8'h10, 8'h10);
        run_tab();
        pulse_fs();
        add(300, 120, 8'h10, 8'hFC);
        add(320, 100, 8'h10, 8'hFC);
        add(510,  10, 8'h10, 8'hE0);
        add(520,  20, 8'h11, 8'hE0);
        add(  0,   0, 8'h11, 8'hFC);
        run_tab();

        // 3: inverted box never draws
        set_box(0, 2, 200, 100, 50, 60);
        pulse_fs();
        add(100, 55, 8'h31, 8'h31);
        add(200, 55, 8'h32, 8'h32);
        add(150, 50, 8'h33, 8'h33);
        run_tab();

        // 4: blink, half-period of two frames
        blink_en = 1'b1;
        set_state(1, 4'd4);
        pulse_fs();
        add(320, 100, 8'h22, 8'hE0);
        add(510,  10, 8'h22, 8'hE0);
        run_tab();
        step(320, 100, 1'b1, 8'h22, 1'b1, 8'hE0, 1'b1);
        add(320, 100, 8'h22, 8'h22);
        add(510,  10, 8'h23, 8'h23);
        add(300, 120, 8'h24, 8'h24);
        run_tab();
        pulse_fs();
        add(320, 100, 8'h25, 8'h25);
        run_tab();
        pulse_fs();
        add(320, 100, 8'h26, 8'hE0);
        run_tab();

        // 5: overlay disabled, only transparency mapping remains
        debug_en = 1'b0;
        pulse_fs();
        add(320, 100, 8'h22, 8'h22);
        add(320, 100, 8'hE3, 8'h7B);
        add(  0,   0, 8'h11, 8'h11);
        run_tab();
        step(320, 100, 1'b0, 8'hE3, 1'b0, 8'h00, 1'b1);

        // 6: reset with the pipeline full
        debug_en = 1'b1;
        pulse_fs();
        step(320, 100, 1'b1, 8'hE3, 1'b0, 8'h00, 1'b0);
        step(320, 100, 1'b1, 8'hE3, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        step(320, 100, 1'b1, 8'hE3, 1'b0, 8'h00, 1'b0);
        chk("midreset color_out", color_out, 8'h00);
        chk("midreset color_valid", {7'd0, color_valid}, 8'h00);
        rst_n = 1'b1;
        step(0, 0, 1'b0, 8'h11, 1'b0, 8'h00, 1'b1);
        add(  0,   0, 8'h11, 8'h11);
        add(320, 100, 8'h22, 8'h22);
        run_tab();
        pulse_fs();
        add(320, 100, 8'h22, 8'hE0);
        add(  0,   0, 8'h11, 8'hFC);
        run_tab();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs never observed, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
